// File: rtl/conv_window_gen_if.sv
// Streaming bus between the pixel source, the window generator and the convolution engine.
// The master side drives pixels and samples windows; the slave side is the window generator.
interface conv_window_gen_if #(
    parameter int unsigned CL_IN  = 4,
    parameter int unsigned KERNEL = 3,
    parameter int unsigned N      = 4
);
    logic [CL_IN*N-1:0]               pix_in;
    logic                             en_in;
    logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv;
    logic                             en_out;
    logic                             eof_out;

    modport master (
        output pix_in,
        output en_in,
        input  data2conv,
        input  en_out,
        input  eof_out
    );

    modport slave (
        input  pix_in,
        input  en_in,
        output data2conv,
        output en_out,
        output eof_out
    );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL window generator for a raster-order multi-channel pixel stream.
// Buffers KERNEL-1 lines and emits one window per valid output position.
module conv_window_gen #(
    parameter int unsigned CL_IN  = 4,
    parameter int unsigned KERNEL = 3,
    parameter int unsigned N      = 4,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_gen_if.slave bus
);
    localparam int unsigned PW = CL_IN * N;
    localparam int unsigned WW = CL_IN * KERNEL * KERNEL * N;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic [KERNEL-1:0][KERNEL-1:0][PW-1:0] win_q, win_d;
    logic [KERNEL-1:0][PW-1:0]             slice_c;

    logic [WW-1:0] data_q, data_d;
    logic          en_out_q, en_out_d;
    logic          eof_q, eof_d;

    logic col_last_c;
    logic row_last_c;
    logic win_valid_c;

    assign col_last_c = (col_q == CW'(IMG_W - 1));
    assign row_last_c = (row_q == RW'(IMG_H - 1));

    // Newest vertical slice: bottom row straight from the input, upper rows from the line buffers.
    assign slice_c[KERNEL-1] = bus.pix_in;

    if (KERNEL > 1) begin : g_lb
        logic [PW-1:0] mem    [KERNEL-1][IMG_W];
        logic [PW-1:0] lb_out [KERNEL-1];

        for (genvar j = 0; j < int'(KERNEL) - 1; j++) begin : g_tap
            assign lb_out[j]             = mem[j][col_q];
            assign slice_c[KERNEL-2-j]   = lb_out[j];
        end

        // Circular line buffers sharing the column pointer; contents need no reset.
        always_ff @(posedge clk) begin
            if (bus.en_in) begin
                mem[0][col_q] <= bus.pix_in;
                for (int j = 1; j < int'(KERNEL) - 1; j++) begin
                    mem[j][col_q] <= lb_out[j-1];
                end
            end
        end

        assign win_valid_c = (row_q >= RW'(KERNEL - 1)) && (col_q >= CW'(KERNEL - 1));
    end else begin : g_nolb
        assign win_valid_c = 1'b1;
    end

    // Next-state: raster counters, window shift and output capture.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        win_d    = win_q;
        data_d   = data_q;
        en_out_d = 1'b0;
        eof_d    = 1'b0;

        if (bus.en_in) begin
            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            for (int r = 0; r < int'(KERNEL); r++) begin
                for (int c = 0; c + 1 < int'(KERNEL); c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERNEL-1] = slice_c[r];
            end

            if (win_valid_c) begin
                en_out_d = 1'b1;
                eof_d    = row_last_c && col_last_c;
                for (int i = 0; i < int'(CL_IN); i++) begin
                    for (int r = 0; r < int'(KERNEL); r++) begin
                        for (int c = 0; c < int'(KERNEL); c++) begin
                            data_d[i*KERNEL*KERNEL*N + (r*KERNEL + c)*N +: N] = win_d[r][c][i*N +: N];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= '0;
            data_q   <= '0;
            en_out_q <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            data_q   <= data_d;
            en_out_q <= en_out_d;
            eof_q    <= eof_d;
        end
    end

    assign bus.data2conv = data_q;
    assign bus.en_out    = en_out_q;
    assign bus.eof_out   = eof_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: three configurations (K=3 5x4, K=1 4x4, K=5 5x5).
// The driver queues model windows; per-DUT monitors pop and compare on every en_out.
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [199:0] data;
        logic         eof;
        int           stamp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic [199:0] last_a = '0, last_b = '0, last_c = '0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int ra = 0, ca = 0, rb = 0, cb = 0, rc = 0, cc = 0;

    conv_window_gen_if #(.CL_IN(2), .KERNEL(3), .N(4)) bus_a ();
    conv_window_gen_if #(.CL_IN(2), .KERNEL(1), .N(4)) bus_b ();
    conv_window_gen_if #(.CL_IN(2), .KERNEL(5), .N(4)) bus_c ();

    conv_window_gen #(.CL_IN(2), .KERNEL(3), .N(4), .IMG_W(5), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(4), .IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );
    conv_window_gen #(.CL_IN(2), .KERNEL(5), .N(4), .IMG_W(5), .IMG_H(5)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c)
    );

    // Stimulus pixel: ch0 = raster index mod 16, ch1 = 15 - ch0.
    function automatic logic [3:0] ch(input int i, input int r, input int c, input int w);
        int v;
        v = (r * w + c) % 16;
        return (i == 0) ? 4'(v) : 4'(15 - v);
    endfunction

    // Window whose bottom-right pixel is (row, col), packed channel/row/column.
    function automatic logic [199:0] model_win(input int k, input int w, input int row, input int col);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < k; r++)
                for (int c = 0; c < k; c++)
                    m[i*k*k*4 + (r*k + c)*4 +: 4] = ch(i, row - k + 1 + r, col - k + 1 + c, w);
        return m;
    endfunction

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one pixel to DUT d (0=A, 1=B, 2=C) and queue its window if one is due.
    task automatic send(input int d);
        int r, c, k, w, h;
        exp_t e;
        case (d)
            0:       begin r = ra; c = ca; k = 3; w = 5; h = 4; end
            1:       begin r = rb; c = cb; k = 1; w = 4; h = 4; end
            default: begin r = rc; c = cc; k = 5; w = 5; h = 5; end
        endcase
        @(negedge clk);
        e.data  = model_win(k, w, r, c);
        e.eof   = (r == h - 1) && (c == w - 1);
        e.stamp = cyc + 1;
        case (d)
            0: begin
                bus_a.pix_in = {ch(1, r, c, w), ch(0, r, c, w)};
                bus_a.en_in  = 1'b1;
                if (r >= k - 1 && c >= k - 1) q_a.push_back(e);
            end
            1: begin
                bus_b.pix_in = {ch(1, r, c, w), ch(0, r, c, w)};
                bus_b.en_in  = 1'b1;
                if (r >= k - 1 && c >= k - 1) q_b.push_back(e);
            end
            default: begin
                bus_c.pix_in = {ch(1, r, c, w), ch(0, r, c, w)};
                bus_c.en_in  = 1'b1;
                if (r >= k - 1 && c >= k - 1) q_c.push_back(e);
            end
        endcase
        c++;
        if (c == w) begin
            c = 0;
            r++;
            if (r == h) r = 0;
        end
        case (d)
            0:       begin ra = r; ca = c; end
            1:       begin rb = r; cb = c; end
            default: begin rc = r; cc = c; end
        endcase
        @(posedge clk);
        #1;
        bus_a.en_in = 1'b0;
        bus_b.en_in = 1'b0;
        bus_c.en_in = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_data"}, bus_a.data2conv, '0);
        chk({tag, "_a_en"},   bus_a.en_out,    '0);
        chk({tag, "_a_eof"},  bus_a.eof_out,   '0);
        chk({tag, "_b_data"}, bus_b.data2conv, '0);
        chk({tag, "_c_data"}, bus_c.data2conv, '0);
        chk({tag, "_c_en"},   bus_c.en_out,    '0);
    endtask

    // Monitors: pop on each window, otherwise the bus must hold its last window.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst) begin
            last_a = '0;
        end else if (bus_a.en_out) begin
            cnt_a++;
            if (q_a.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL a_unexpected_window: got %0h expected none (cycle %0d)", bus_a.data2conv, cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_data",    bus_a.data2conv, e.data);
                chk("a_eof",     bus_a.eof_out,   e.eof);
                chk("a_latency", cyc,             e.stamp);
                last_a = e.data;
            end
        end else begin
            chk("a_hold",     bus_a.data2conv, last_a);
            chk("a_eof_idle", bus_a.eof_out,   '0);
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst) begin
            last_b = '0;
        end else if (bus_b.en_out) begin
            cnt_b++;
            if (q_b.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL b_unexpected_window: got %0h expected none (cycle %0d)", bus_b.data2conv, cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_data",    bus_b.data2conv, e.data);
                chk("b_eof",     bus_b.eof_out,   e.eof);
                chk("b_latency", cyc,             e.stamp);
                last_b = e.data;
            end
        end else begin
            chk("b_hold", bus_b.data2conv, last_b);
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst) begin
            last_c = '0;
        end else if (bus_c.en_out) begin
            cnt_c++;
            if (q_c.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL c_unexpected_window: got %0h expected none (cycle %0d)", bus_c.data2conv, cyc);
            end else begin
                e = q_c.pop_front();
                chk("c_data",    bus_c.data2conv, e.data);
                chk("c_eof",     bus_c.eof_out,   e.eof);
                chk("c_latency", cyc,             e.stamp);
                last_c = e.data;
            end
        end else begin
            chk("c_hold", bus_c.data2conv, last_c);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    int gaps [20] = '{0, 3, 1, 5, 0, 2, 4, 0, 1, 5, 3, 0, 2, 1, 0, 4, 5, 0, 2, 3};

    initial begin : stim
        bus_a.en_in = 1'b0; bus_a.pix_in = '0;
        bus_b.en_in = 1'b0; bus_b.pix_in = '0;
        bus_c.en_in = 1'b0; bus_c.pix_in = '0;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame.
        for (int i = 0; i < 20; i++) send(0);
        drain();
        chk("a_cont_count", cnt_a, 6);

        // Same frame with idle gaps between pixels.
        for (int i = 0; i < 20; i++) begin
            send(0);
            repeat (gaps[i]) @(negedge clk);
        end
        drain();
        chk("a_gap_count", cnt_a, 12);

        // Two back-to-back frames.
        for (int i = 0; i < 40; i++) send(0);
        drain();
        chk("a_b2b_count", cnt_a, 24);

        // Reset after seven accepted pixels, then a full frame.
        for (int i = 0; i < 7; i++) send(0);
        @(negedge clk);
        rst = 1'b1;
        ra = 0; ca = 0;
        #1;
        chk_reset_outputs("mid");
        @(posedge clk);
        #1;
        chk_reset_outputs("mid_clk");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) send(0);
        drain();
        chk("a_reset_count", cnt_a, 30);

        // KERNEL=1: every pixel is its own window.
        for (int i = 0; i < 16; i++) send(1);
        drain();
        chk("b_count", cnt_b, 16);

        // KERNEL=5: a single full-image window.
        for (int i = 0; i < 25; i++) send(2);
        drain();
        chk("c_count", cnt_c, 1);

        chk("a_queue_empty", 200'(q_a.size()), '0);
        chk("b_queue_empty", 200'(q_b.size()), '0);
        chk("c_queue_empty", 200'(q_c.size()), '0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
